alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 45 ++++
 rtl/alu_op_decode.sv | 29 ++
 rtl/alu_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
//------------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU instruction sequencer:
//   - state_t   : control-step states of the sequencer FSM
//   - OP_*      : ALU opcode constants, including OP_INCPC used during fetch
//   - *_MSB/LSB : bit positions of the opcode and register fields in IR
// Optional feature macro used by the sequencer: MEM_WAIT_EN
//------------------------------------------------------------------------------
`timescale 1ns/1ps

package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_DONE
  } state_t;

  localparam logic [4:0] OP_NONE  = 5'b00000;
  localparam logic [4:0] OP_ADD   = 5'b00011;
  localparam logic [4:0] OP_SUB   = 5'b00100;
  localparam logic [4:0] OP_AND   = 5'b00101;
  localparam logic [4:0] OP_OR    = 5'b00110;
  localparam logic [4:0] OP_ROR   = 5'b00111;
  localparam logic [4:0] OP_ROL   = 5'b01000;
  localparam logic [4:0] OP_SHR   = 5'b01001;
  localparam logic [4:0] OP_SHRA  = 5'b01010;
  localparam logic [4:0] OP_SHL   = 5'b01011;
  localparam logic [4:0] OP_INCPC = 5'b11111;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

endpackage

// File: rtl/alu_op_decode.sv
//------------------------------------------------------------------------------
// alu_op_decode
// Combinational legality check for the ALU opcode field of IR.
// Ports:
//   i_opcode : ir[31:27], the instruction opcode
//   o_legal  : 1 when the opcode is one of the ALU operations the sequencer
//              knows how to execute
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module alu_op_decode
  import alu_seq_pkg::*;
(
  input  logic [4:0] i_opcode,
  output logic       o_legal
);

  // Only the nine register-to-register ALU operations are executable; every
  // other code, including the internal IncPC code, is treated as illegal.
  always_comb begin
    o_legal = 1'b0;
    case (i_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL: o_legal = 1'b1;
      default:                         o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
//------------------------------------------------------------------------------
// alu_sequencer
// Moore control unit that fetches an instruction and steps a three-register
// ALU operation (Ra <= Rb op Rc) through the datapath in control steps T0-T5.
// Ports:
//   clock        : rising-edge clock
//   clear        : synchronous active-low reset, returns the FSM to IDLE
//   run          : start request, sampled in IDLE and DONE
//   ir           : IR contents (opcode [31:27], Ra [26:23], Rb [22:19],
//                  Rc [18:15])
//   mem_rdy      : memory ready, only present when MEM_WAIT_EN is defined
//   PCout..Zlowout : datapath strobes
//   reg_out_en/sel : drive the selected GPR onto the bus
//   reg_in_en/sel  : load the selected GPR from the bus
//   opcode       : ALU operation code
//   busy         : high in every state except IDLE
//   done         : one-cycle pulse in the completion state
//   illegal      : one-cycle pulse when an unsupported opcode reaches T3
// Optional feature: MEM_WAIT_EN makes T1 wait for mem_rdy before advancing.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
`ifdef MEM_WAIT_EN
  input  logic        mem_rdy,
`endif
  output logic        PCout,
  output logic        MARin,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        ZlowIn,
  output logic        Zlowout,
  output logic        reg_out_en,
  output logic [3:0]  reg_out_sel,
  output logic        reg_in_en,
  output logic [3:0]  reg_in_sel,
  output logic [4:0]  opcode,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  state_t     r_state;
  state_t     w_nextState;
  logic       w_legal;
  logic [4:0] w_irOpcode;
  logic [3:0] w_ra;
  logic [3:0] w_rb;
  logic [3:0] w_rc;
  logic       w_memReady;
  logic       w_unusedIr;

  assign w_irOpcode = ir[OPC_MSB:OPC_LSB];
  assign w_ra       = ir[RA_MSB:RA_LSB];
  assign w_rb       = ir[RB_MSB:RB_LSB];
  assign w_rc       = ir[RC_MSB:RC_LSB];

  // The low IR bits carry no information for ALU instructions; they are
  // folded into a dummy so the whole IR port is visibly consumed.
  assign w_unusedIr = ^ir[RC_LSB-1:0];

  // Without the memory-wait option the fetch read always completes in a
  // single T1 cycle, so the ready condition is simply tied high.
`ifdef MEM_WAIT_EN
  assign w_memReady = mem_rdy;
`else
  assign w_memReady = 1'b1;
`endif

  alu_op_decode u_opDecode (
    .i_opcode (w_irOpcode),
    .o_legal  (w_legal)
  );

  // State register. Reset has priority over everything, so a run request in
  // the same cycle as clear=0 is ignored and an instruction in flight is
  // abandoned without ever reaching its register-write step.
  always_ff @(posedge clock) begin
    if (!clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and Moore output decode. Every output starts at its inactive
  // value so that each state only has to name the strobes it raises; the
  // register selects and ALU opcode are driven from IR only in the steps
  // that actually use them and are zero everywhere else.
  always_comb begin
    w_nextState = r_state;
    PCout       = 1'b0;
    MARin       = 1'b0;
    PCin        = 1'b0;
    Read        = 1'b0;
    MDRin       = 1'b0;
    MDRout      = 1'b0;
    IRin        = 1'b0;
    Yin         = 1'b0;
    ZlowIn      = 1'b0;
    Zlowout     = 1'b0;
    reg_out_en  = 1'b0;
    reg_out_sel = 4'h0;
    reg_in_en   = 1'b0;
    reg_in_sel  = 4'h0;
    opcode      = OP_NONE;
    busy        = 1'b1;
    done        = 1'b0;
    illegal     = 1'b0;

    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (run) begin
          w_nextState = S_T0;
        end
      end
      S_T0: begin
        PCout       = 1'b1;
        MARin       = 1'b1;
        ZlowIn      = 1'b1;
        opcode      = OP_INCPC;
        w_nextState = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        if (w_memReady) begin
          w_nextState = S_T2;
        end
      end
      S_T2: begin
        MDRout      = 1'b1;
        IRin        = 1'b1;
        w_nextState = S_T3;
      end
      S_T3: begin
        reg_out_en  = 1'b1;
        reg_out_sel = w_rb;
        Yin         = 1'b1;
        if (w_legal) begin
          w_nextState = S_T4;
        end else begin
          illegal     = 1'b1;
          w_nextState = S_IDLE;
        end
      end
      S_T4: begin
        reg_out_en  = 1'b1;
        reg_out_sel = w_rc;
        opcode      = w_irOpcode;
        ZlowIn      = 1'b1;
        w_nextState = S_T5;
      end
      S_T5: begin
        Zlowout     = 1'b1;
        reg_in_en   = 1'b1;
        reg_in_sel  = w_ra;
        w_nextState = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (run) begin
          w_nextState = S_T0;
        end else begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        busy        = 1'b0;
        w_nextState = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
//------------------------------------------------------------------------------
// tb_alu_sequencer
// Self-checking bench for alu_sequencer: a table of hand-derived instruction
// vectors, randomized instructions checked against a cycle-step reference
// model, and hand-written sequences for reset, back-to-back execution,
// mid-instruction clear and (with MEM_WAIT_EN) the memory wait in T1.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_alu_sequencer;

  logic        clock;
  logic        clear;
  logic        run;
  logic [31:0] ir;
`ifdef MEM_WAIT_EN
  logic        memRdy;
`endif
  logic        PCout, MARin, PCin, Read, MDRin, MDRout, IRin, Yin;
  logic        ZlowIn, Zlowout, reg_out_en, reg_in_en, busy, done, illegal;
  logic [3:0]  reg_out_sel, reg_in_sel;
  logic [4:0]  opcode;
  logic [27:0] actualOut;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    logic [31:0] ir;
    logic        expLegal;
    logic [4:0]  expOp;
    logic [3:0]  expRa;
    logic [3:0]  expRb;
    logic [3:0]  expRc;
  } vec_t;

  vec_t vecs[8];

  alu_sequencer dut (
    .clock       (clock),
    .clear       (clear),
    .run         (run),
    .ir          (ir),
`ifdef MEM_WAIT_EN
    .mem_rdy     (memRdy),
`endif
    .PCout       (PCout),
    .MARin       (MARin),
    .PCin        (PCin),
    .Read        (Read),
    .MDRin       (MDRin),
    .MDRout      (MDRout),
    .IRin        (IRin),
    .Yin         (Yin),
    .ZlowIn      (ZlowIn),
    .Zlowout     (Zlowout),
    .reg_out_en  (reg_out_en),
    .reg_out_sel (reg_out_sel),
    .reg_in_en   (reg_in_en),
    .reg_in_sel  (reg_in_sel),
    .opcode      (opcode),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal)
  );

  assign actualOut = {PCout, MARin, PCin, Read, MDRin, MDRout, IRin, Yin,
                      ZlowIn, Zlowout, reg_out_en, reg_out_sel, reg_in_en,
                      reg_in_sel, opcode, busy, done, illegal};

  // Free-running 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to just after the next rising edge, where outputs are settled
  // and new inputs can be applied for the following edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] irv, input logic runv,
                               input logic clearv);
    ir    = irv;
    run   = runv;
    clear = clearv;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, actual,
               expected, $time);
    end
  endtask

  // The executable opcodes form the contiguous range 3..11.
  function automatic logic isLegal(input logic [31:0] irv);
    int op;
    op = int'(irv[31:27]);
    return (op >= 3) && (op <= 11);
  endfunction

  function automatic logic [31:0] mkIr(input logic [4:0] op,
                                       input logic [3:0] ra,
                                       input logic [3:0] rb,
                                       input logic [3:0] rc);
    return {op, ra, rb, rc, 15'h0};
  endfunction

  // Expected output bundle for the k-th cycle of an instruction
  // (k=0 idle, 1..6 control steps T0..T5, 7 completion).
  function automatic logic [27:0] modelOut(input logic [31:0] irv, input int k);
    logic [9:0] s;
    logic       roe, rie, bz, dn, il;
    logic [3:0] ros, ris;
    logic [4:0] op;
    s = '0; roe = 0; rie = 0; dn = 0; il = 0; ros = '0; ris = '0; op = '0;
    bz = (k != 0);
    case (k)
      1: begin s = 10'b1100000010; op = 5'b11111; end
      2: s = 10'b0011100001;
      3: s = 10'b0000011000;
      4: begin s = 10'b0000000100; roe = 1; ros = irv[22:19]; il = !isLegal(irv); end
      5: begin s = 10'b0000000010; roe = 1; ros = irv[18:15]; op = irv[31:27]; end
      6: begin s = 10'b0000000001; rie = 1; ris = irv[26:23]; end
      7: dn = 1;
      default: ;
    endcase
    return {s, roe, ros, rie, ris, op, bz, dn, il};
  endfunction

  // Launch one instruction from IDLE and compare every cycle to the model.
  task automatic runInstr(input logic [31:0] irv, input string tag);
    int steps;
    steps = isLegal(irv) ? 7 : 4;
    applyStimulus(irv, 1'b1, 1'b1);
    tick();
    run = 1'b0;
    for (int k = 1; k <= steps; k++) begin
      checkOutput(tag, {4'h0, actualOut}, {4'h0, modelOut(irv, k)});
      tick();
    end
    checkOutput({tag, "_idle"}, {4'h0, actualOut}, {4'h0, modelOut(irv, 0)});
  endtask

  // Table vector: check only the fields the record specifies.
  task automatic runVector(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    applyStimulus(v.ir, 1'b1, 1'b1);
    tick();
    run = 1'b0;
    checkOutput({tag, "_T0"}, {24'h0, PCout, MARin, ZlowIn, opcode},
                {24'h0, 3'b111, 5'b11111});
    tick();
    tick();
    tick();
    checkOutput({tag, "_T3"}, {25'h0, reg_out_en, reg_out_sel, Yin, illegal},
                {25'h0, 1'b1, v.expRb, 1'b1, !v.expLegal});
    if (v.expLegal) begin
      tick();
      checkOutput({tag, "_T4"}, {21'h0, reg_out_en, reg_out_sel, opcode, ZlowIn},
                  {21'h0, 1'b1, v.expRc, v.expOp, 1'b1});
      tick();
      checkOutput({tag, "_T5"}, {26'h0, Zlowout, reg_in_en, reg_in_sel},
                  {26'h0, 1'b1, 1'b1, v.expRa});
      tick();
      checkOutput({tag, "_done"}, {30'h0, done, busy}, {30'h0, 1'b1, 1'b1});
    end
    tick();
    checkOutput({tag, "_idle"}, {29'h0, busy, done, reg_in_en}, 32'h0);
  endtask

  initial begin
    int firstDone;
    int secondDone;
    int doneAt;
    logic seenWrite;
    logic [31:0] rnd;
    logic [31:0] irv;
    logic [4:0]  op;

    vecs[0] = '{32'h5A1B8000, 1'b1, 5'b01011, 4'd4, 4'd3, 4'd7};
    vecs[1] = '{32'h4A1B8000, 1'b1, 5'b01001, 4'd4, 4'd3, 4'd7};
    vecs[2] = '{32'hF8000000, 1'b0, 5'b11111, 4'd0, 4'd0, 4'd0};
    vecs[3] = '{32'h18918000, 1'b1, 5'b00011, 4'd1, 4'd2, 4'd3};
    vecs[4] = '{32'h10918000, 1'b0, 5'b00010, 4'd1, 4'd2, 4'd3};
    vecs[5] = '{32'h63FF8000, 1'b0, 5'b01100, 4'd7, 4'd15, 4'd15};
    vecs[6] = '{32'h00000000, 1'b0, 5'b00000, 4'd0, 4'd0, 4'd0};
    vecs[7] = '{32'h27FF8000, 1'b1, 5'b00100, 4'd15, 4'd15, 4'd15};

`ifdef MEM_WAIT_EN
    memRdy = 1'b1;
`endif
    // Reset held for two cycles
    applyStimulus(32'h0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset_outputs", {4'h0, actualOut}, 32'h0);
    clear = 1'b1;
    tick();

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      runVector(vecs[i], i);
    end

    // Randomized instructions against the reference model
    for (int i = 0; i < 24; i++) begin
      rnd = $urandom();
      op  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                        : 5'($urandom_range(3, 11));
      irv = {op, rnd[26:0]};
      runInstr(irv, $sformatf("rand%0d_op%0d", i, op));
    end

    // Back-to-back execution with run held high
    irv = 32'h4A1B8000;
    firstDone  = 0;
    secondDone = 0;
    applyStimulus(irv, 1'b1, 1'b1);
    for (int c = 1; c <= 14; c++) begin
      tick();
      checkOutput($sformatf("b2b_c%0d", c), {4'h0, actualOut},
                  {4'h0, modelOut(irv, ((c - 1) % 7) + 1)});
      if (done && firstDone == 0) firstDone = c;
      else if (done) secondDone = c;
    end
    run = 1'b0;
    tick();
    checkOutput("b2b_idle", {4'h0, actualOut}, 32'h0);
    checkOutput("b2b_first_done", firstDone, 7);
    checkOutput("b2b_done_spacing", secondDone - firstDone, 7);

    // Clear asserted during T4 (with run high, which must be ignored)
    applyStimulus(32'h5A1B8000, 1'b1, 1'b1);
    tick();
    run = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    checkOutput("clr_at_T4", {27'h0, ZlowIn, opcode}, {27'h0, 1'b1, 5'b01011});
    applyStimulus(32'h5A1B8000, 1'b1, 1'b0);
    tick();
    checkOutput("clr_idle", {4'h0, actualOut}, 32'h0);
    applyStimulus(32'h5A1B8000, 1'b0, 1'b1);
    seenWrite = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ZlowIn || reg_in_en) seenWrite = 1'b1;
    end
    checkOutput("clr_no_write", {31'h0, seenWrite}, 32'h0);

`ifdef MEM_WAIT_EN
    // T1 held while memory is not ready
    irv = 32'h5A1B8000;
    applyStimulus(irv, 1'b1, 1'b1);
    tick();
    run    = 1'b0;
    memRdy = 1'b0;
    doneAt = 0;
    for (int c = 2; c <= 30 && doneAt == 0; c++) begin
      tick();
      if (c <= 5) checkOutput($sformatf("mem_T1_c%0d", c), {4'h0, actualOut},
                              {4'h0, modelOut(irv, 2)});
      if (done) doneAt = c;
      memRdy = (c >= 5);
    end
    checkOutput("mem_done_cycle", doneAt, 10);
    tick();
    checkOutput("mem_idle", {4'h0, actualOut}, 32'h0);
`else
    doneAt = 0;
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
